// File: rtl/stage_accumulator.sv
// Per-stage leaf-value accumulator: sums signed leaves until eot, compares against a ROM threshold, emits one verdict per window.
// Verdict valid two cycles after the window's final eot; din_ready drops in COMPARE/REPORT and stays low while dout_ready is low.
module stage_accumulator #(
  parameter  int W_LEAF       = 14,
  parameter  int W_ACC        = 22,
  parameter  int W_STAGE_THR  = 22,
  parameter  int STAGE_NUM    = 25,
  localparam int W_ADDR_STAGE = $clog2(STAGE_NUM)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           din_valid,
  output logic                           din_ready,
  input  logic signed [W_LEAF-1:0]       din_data,
  input  logic                           din_eot,
  output logic        [W_ADDR_STAGE-1:0] thr_addr,
  input  logic signed [W_STAGE_THR-1:0]  thr_data,
  output logic                           dout_valid,
  input  logic                           dout_ready,
  output logic                           dout_detect,
  output logic        [W_ADDR_STAGE-1:0] dout_stage
);

  localparam int W_CMP = (W_ACC > W_STAGE_THR) ? W_ACC : W_STAGE_THR;
  localparam logic [W_ADDR_STAGE-1:0] LAST_STAGE = W_ADDR_STAGE'(STAGE_NUM - 1);

  typedef enum logic [1:0] {
    S_ACC     = 2'd0,
    S_COMPARE = 2'd1,
    S_DRAIN   = 2'd2,
    S_REPORT  = 2'd3
  } state_t;

  state_t                        r_state;
  logic signed [W_ACC-1:0]       r_acc;
  logic        [W_ADDR_STAGE-1:0] r_stage_cnt;
  logic                          r_dout_valid;
  logic                          r_dout_detect;
  logic        [W_ADDR_STAGE-1:0] r_dout_stage;

  state_t                        w_state_nxt;
  logic signed [W_ACC-1:0]       w_acc_nxt;
  logic        [W_ADDR_STAGE-1:0] w_stage_cnt_nxt;
  logic                          w_detect_nxt;
  logic        [W_ADDR_STAGE-1:0] w_dout_stage_nxt;

  logic signed [W_ACC-1:0]       w_leaf_ext;
  logic signed [W_CMP-1:0]       w_acc_cmp;
  logic signed [W_CMP-1:0]       w_thr_cmp;
  logic                          w_pass;
  logic                          w_din_fire;
  logic                          w_dout_fire;
  logic                          w_last_stage;

  assign din_ready    = (r_state == S_ACC) || (r_state == S_DRAIN);
  assign w_din_fire   = din_valid && din_ready;
  assign w_dout_fire  = r_dout_valid && dout_ready;
  assign w_last_stage = (r_stage_cnt == LAST_STAGE);

  assign w_leaf_ext = W_ACC'(din_data);
  assign w_acc_cmp  = W_CMP'(r_acc);
  assign w_thr_cmp  = W_CMP'(thr_data);
  assign w_pass     = (w_acc_cmp >= w_thr_cmp);

  assign thr_addr    = r_stage_cnt;
  assign dout_valid  = r_dout_valid;
  assign dout_detect = r_dout_detect;
  assign dout_stage  = r_dout_stage;

  always_comb begin
    w_state_nxt      = r_state;
    w_acc_nxt        = r_acc;
    w_stage_cnt_nxt  = r_stage_cnt;
    w_detect_nxt     = r_dout_detect;
    w_dout_stage_nxt = r_dout_stage;
    case (r_state)
      S_ACC: begin
        if (w_din_fire) begin
          w_acc_nxt = r_acc + w_leaf_ext;
          if (din_eot) begin
            w_state_nxt = S_COMPARE;
          end
        end
      end
      S_COMPARE: begin
        if (w_pass) begin
          if (w_last_stage) begin
            w_detect_nxt     = 1'b1;
            w_dout_stage_nxt = r_stage_cnt;
            w_state_nxt      = S_REPORT;
          end else begin
            w_stage_cnt_nxt = r_stage_cnt + 1'b1;
            w_acc_nxt       = '0;
            w_state_nxt     = S_ACC;
          end
        end else begin
          w_detect_nxt     = 1'b0;
          w_dout_stage_nxt = r_stage_cnt;
          w_acc_nxt        = '0;
          if (w_last_stage) begin
            w_state_nxt = S_REPORT;
          end else begin
            w_stage_cnt_nxt = r_stage_cnt + 1'b1;
            w_state_nxt     = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        // Beats are swallowed only to keep upstream feature indexing in step.
        if (w_din_fire && din_eot) begin
          if (w_last_stage) begin
            w_state_nxt = S_REPORT;
          end else begin
            w_stage_cnt_nxt = r_stage_cnt + 1'b1;
          end
        end
      end
      S_REPORT: begin
        if (w_dout_fire) begin
          w_stage_cnt_nxt = '0;
          w_acc_nxt       = '0;
          w_state_nxt     = S_ACC;
        end
      end
      default: w_state_nxt = S_ACC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_ACC;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Entry from DRAIN spends one REPORT cycle with valid low so both reject paths share the same latency.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_acc         <= '0;
      r_stage_cnt   <= '0;
      r_dout_valid  <= 1'b0;
      r_dout_detect <= 1'b0;
      r_dout_stage  <= '0;
    end else begin
      r_acc         <= w_acc_nxt;
      r_stage_cnt   <= w_stage_cnt_nxt;
      r_dout_valid  <= (w_state_nxt == S_REPORT) && (r_state != S_DRAIN);
      r_dout_detect <= w_detect_nxt;
      r_dout_stage  <= w_dout_stage_nxt;
    end
  end

endmodule

// File: tb/tb_stage_accumulator.sv
// Directed bench for stage_accumulator: three stages, thresholds {10,-5,20}, stage lengths {2,1,3}.
module tb_stage_accumulator;

  localparam int W_LEAF = 14;
  localparam int W_ACC = 22;
  localparam int W_STAGE_THR = 22;
  localparam int STAGE_NUM = 3;
  localparam int W_ADDR_STAGE = $clog2(STAGE_NUM);

  logic                           clk = 1'b0;
  logic                           rst;
  logic                           din_valid;
  logic                           din_ready;
  logic signed [W_LEAF-1:0]       din_data;
  logic                           din_eot;
  logic        [W_ADDR_STAGE-1:0] thr_addr;
  logic signed [W_STAGE_THR-1:0]  thr_data = '0;
  logic                           dout_valid;
  logic                           dout_ready;
  logic                           dout_detect;
  logic        [W_ADDR_STAGE-1:0] dout_stage;

  stage_accumulator #(
    .W_LEAF      (W_LEAF),
    .W_ACC       (W_ACC),
    .W_STAGE_THR (W_STAGE_THR),
    .STAGE_NUM   (STAGE_NUM)
  ) u_dut (
    .clk         (clk),
    .rst         (rst),
    .din_valid   (din_valid),
    .din_ready   (din_ready),
    .din_data    (din_data),
    .din_eot     (din_eot),
    .thr_addr    (thr_addr),
    .thr_data    (thr_data),
    .dout_valid  (dout_valid),
    .dout_ready  (dout_ready),
    .dout_detect (dout_detect),
    .dout_stage  (dout_stage)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic signed [W_STAGE_THR-1:0] rom [STAGE_NUM];
  always @(posedge clk) thr_data <= (int'(thr_addr) < STAGE_NUM) ? rom[thr_addr] : '0;

  int n_checks = 0;
  int n_errors = 0;
  int leaves[6];
  logic [5:0] eot_mask = 6'b100110;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting posedge.
  task automatic send(input int d, input bit e, output int present_cyc);
    int n;
    din_valid = 1'b1;
    din_data  = W_LEAF'(d);
    din_eot   = e;
    n = 0;
    while (!din_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("din_ready_timeout", 0, 1);
    present_cyc = cyc;
    @(posedge clk);
    @(negedge clk);
    din_valid = 1'b0;
    din_eot   = 1'b0;
  endtask

  task automatic send_window(input bit bubbles, output int last_cyc);
    int pc;
    for (int i = 0; i < 6; i++) begin
      if (bubbles && i > 0) @(negedge clk);
      send(leaves[i], eot_mask[i], pc);
    end
    last_cyc = pc;
  endtask

  task automatic get_verdict(input string nm, input int last_cyc, input bit exp_det,
                             input int exp_stg, input bit hold);
    int n;
    n = 0;
    while (!dout_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check({nm, "_valid_timeout"}, 0, 1);
    check({nm, "_latency"}, cyc - last_cyc, 2);
    check({nm, "_detect"}, dout_detect, exp_det);
    check({nm, "_stage"}, dout_stage, exp_stg);
    if (hold) begin
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        check({nm, "_hold_valid"}, dout_valid, 1);
        check({nm, "_hold_detect"}, dout_detect, exp_det);
        check({nm, "_hold_stage"}, dout_stage, exp_stg);
        check({nm, "_hold_din_ready"}, din_ready, 0);
      end
      dout_ready = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    check({nm, "_post_valid"}, dout_valid, 0);
    check({nm, "_post_thr_addr"}, thr_addr, 0);
    check({nm, "_post_din_ready"}, din_ready, 1);
  endtask

  initial begin
    int last;
    int pc;
    rom[0] = 22'sd10;
    rom[1] = -22'sd5;
    rom[2] = 22'sd20;
    rst        = 1'b0;
    din_valid  = 1'b0;
    din_data   = '0;
    din_eot    = 1'b0;
    dout_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_dout_valid", dout_valid, 0);
    check("rst_dout_detect", dout_detect, 0);
    check("rst_dout_stage", dout_stage, 0);
    check("rst_thr_addr", thr_addr, 0);
    check("rst_din_ready", din_ready, 1);
    rst = 1'b1;
    @(negedge clk);

    leaves = '{4, 6, -5, 7, 7, 6};
    send_window(1'b0, last);
    get_verdict("full_pass", last, 1'b1, 2, 1'b0);

    leaves = '{4, 5, 0, 9, 9, 9};
    send_window(1'b0, last);
    get_verdict("early_reject", last, 1'b0, 0, 1'b0);

    leaves = '{20, -3, -1, 10, -2, 11};
    send_window(1'b0, last);
    get_verdict("last_reject", last, 1'b0, 2, 1'b0);

    leaves = '{4, 6, -5, 7, 7, 6};
    dout_ready = 1'b0;
    send_window(1'b0, last);
    get_verdict("backpressure", last, 1'b1, 2, 1'b1);

    send(4, 1'b0, pc);
    send(6, 1'b1, pc);
    @(negedge clk);
    check("midrst_thr_addr_before", thr_addr, 1);
    send(-50, 1'b0, pc);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_dout_valid", dout_valid, 0);
    check("midrst_thr_addr", thr_addr, 0);
    check("midrst_din_ready", din_ready, 1);
    rst = 1'b1;
    @(negedge clk);
    send_window(1'b0, last);
    get_verdict("after_reset", last, 1'b1, 2, 1'b0);

    send_window(1'b1, last);
    get_verdict("bubbles", last, 1'b1, 2, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
